// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Writeback stage driving the register file write port (c_addr/c_we/c_in).
//   Single-cycle ALU results have fixed priority and no backpressure; multi-cycle
//   mul/div results are queued in a small FIFO and drained whenever the ALU is
//   idle. At most one register file write is issued per cycle. A scoreboard
//   (busy_mask) tracks registers with a mul/div write still outstanding so the
//   upstream hazard logic can stall dependent instructions.
//
// Parameters
//   DEPTH   mul/div result FIFO entries (power of 2, >= 2)
//   DATA_W  result data width
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   alu_valid/addr/data        ALU result, claims the write port when valid
//   md_issue, md_issue_addr    mul/div op issued; marks destination busy
//   md_valid/addr/data         mul/div result offered
//   md_ready                   FIFO can accept a result (not full)
//   busy_mask                  bit i set = reg i has a pending mul/div write
//   c_addr, c_we, c_in         registered register file write port
//
// Configuration macro
//   WB_BYPASS_EN  when defined, a mul/div result arriving with the FIFO empty
//                 and the ALU idle is written directly at the next edge
//                 instead of being queued.
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [4:0]        alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              md_issue,
    input  logic [4:0]        md_issue_addr,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [4:0]        md_addr,
    input  logic [DATA_W-1:0] md_data,
    output logic [31:0]       busy_mask,
    output logic [4:0]        c_addr,
    output logic              c_we,
    output logic [DATA_W-1:0] c_in
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [4:0]        addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              fifo_empty;
    logic              push, pop, bypass;
    logic              sel_valid;
    logic [4:0]        sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [31:0]       set_mask, clr_mask;

    assign fifo_empty = (count == '0);
    // Ready depends on the current occupancy only: a full FIFO refuses a push
    // even when the same edge pops an entry.
    assign md_ready   = (count != CNT_FULL);

`ifdef WB_BYPASS_EN
    assign bypass = md_valid && fifo_empty && !alu_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push = md_valid && md_ready && !bypass;
    assign pop  = !alu_valid && !fifo_empty;

    // Write-port source selection: ALU first, then FIFO head, then bypass.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path through the block leaves it unassigned (no latch inferred).
        sel_valid = 1'b0;
        sel_addr  = alu_addr;
        sel_data  = alu_data;
        clr_mask  = '0;
        set_mask  = '0;
        if (alu_valid) begin
            sel_valid = 1'b1;
        end else if (pop) begin
            sel_valid = 1'b1;
            sel_addr  = addr_q[rd_ptr];
            sel_data  = data_q[rd_ptr];
            clr_mask[addr_q[rd_ptr]] = 1'b1;
        end else if (bypass) begin
            sel_valid = 1'b1;
            sel_addr  = md_addr;
            sel_data  = md_data;
            clr_mask[md_addr] = 1'b1;
        end
        // Register 0 is never tracked; a same-edge set beats the clear.
        if (md_issue && (md_issue_addr != 5'd0))
            set_mask[md_issue_addr] = 1'b1;
    end

    // NOTE: the FIFO storage has no reset; occupancy is governed solely by
    // count/pointers, so stale contents are never observed and the array can
    // map onto plain flops or RAM without a reset network.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= md_addr;
            data_q[wr_ptr] <= md_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            busy_mask <= '0;
            c_we      <= 1'b0;
            c_addr    <= '0;
            c_in      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            busy_mask <= (busy_mask & ~clr_mask) | set_mask;

            // Writes to r0 are suppressed but the port address/data still
            // track the selection; with nothing selected they hold.
            c_we <= sel_valid && (sel_addr != 5'd0);
            if (sel_valid) begin
                c_addr <= sel_addr;
                c_in   <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//   Directed self-checking bench for wb_arbiter (DEPTH=4, DATA_W=32). Inputs
//   change 1 ns after a rising edge and outputs are sampled at that point, so
//   each tick() shows the result of exactly one clock edge.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        md_issue;
    logic [4:0]  md_issue_addr;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic [31:0] busy_mask;
    logic [4:0]  c_addr;
    logic        c_we;
    logic [31:0] c_in;

    int n_checks = 0;
    int n_pass   = 0;

    wb_arbiter #(.DEPTH(4), .DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .alu_addr      (alu_addr),
        .alu_data      (alu_data),
        .md_issue      (md_issue),
        .md_issue_addr (md_issue_addr),
        .md_valid      (md_valid),
        .md_ready      (md_ready),
        .md_addr       (md_addr),
        .md_data       (md_data),
        .busy_mask     (busy_mask),
        .c_addr        (c_addr),
        .c_we          (c_we),
        .c_in          (c_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        md_issue  = 1'b0; md_issue_addr = '0;
        md_valid  = 1'b0; md_addr = '0; md_data = '0;
    endtask

    initial begin
        int pushed;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        check("rst_c_we",     32'(c_we), 32'd0);
        check("rst_c_addr",   32'(c_addr), 32'd0);
        check("rst_c_in",     c_in, 32'd0);
        check("rst_busy",     busy_mask, 32'd0);
        check("rst_md_ready", 32'(md_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // ALU write, 1-cycle latency
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h0000_1234;
        tick();
        check("alu_we",   32'(c_we), 32'd1);
        check("alu_addr", 32'(c_addr), 32'd5);
        check("alu_data", c_in, 32'h0000_1234);

        // ALU write to r0: enable suppressed, addr/data still updated
        alu_addr = 5'd0; alu_data = 32'hFFFF_FFFF;
        tick();
        check("r0_we",   32'(c_we), 32'd0);
        check("r0_addr", 32'(c_addr), 32'd0);
        check("r0_data", c_in, 32'hFFFF_FFFF);
        idle_inputs();
        tick();
        check("idle_we",   32'(c_we), 32'd0);
        check("idle_data", c_in, 32'hFFFF_FFFF);

        // mul/div issue and result to r7
        md_issue = 1'b1; md_issue_addr = 5'd7;
        tick();
        check("issue7_busy", busy_mask, 32'h0000_0080);
        md_issue = 1'b0;
        md_valid = 1'b1; md_addr = 5'd7; md_data = 32'hDEAD_BEEF;
        tick();
        md_valid = 1'b0;
`ifndef WB_BYPASS_EN
        check("md7_push_we",   32'(c_we), 32'd0);
        check("md7_push_busy", busy_mask, 32'h0000_0080);
        tick();
`endif
        check("md7_we",   32'(c_we), 32'd1);
        check("md7_addr", 32'(c_addr), 32'd7);
        check("md7_data", c_in, 32'hDEAD_BEEF);
        check("md7_busy", busy_mask, 32'd0);
        tick();
        check("md7_after_we", 32'(c_we), 32'd0);

        // Mark r10..r14 busy
        for (int k = 0; k < 5; k++) begin
            md_issue = 1'b1; md_issue_addr = 5'(10 + k);
            tick();
        end
        md_issue = 1'b0;
        check("busy_10_14", busy_mask, 32'h0000_7C00);

        // ALU busy 6 cycles while 5 md results are offered: 4 accepted
        pushed = 0;
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1'b1; alu_addr = 5'(i + 1); alu_data = 32'h00A0 + 32'(i);
            md_valid  = 1'b1; md_addr = 5'(10 + pushed); md_data = 32'h0100 + 32'(pushed);
            check($sformatf("fill_ready_%0d", i), 32'(md_ready), (i < 4) ? 32'd1 : 32'd0);
            tick();
            if (i < 4) pushed++;
            check($sformatf("fill_addr_%0d", i), 32'(c_addr), 32'(i + 1));
            check($sformatf("fill_we_%0d", i), 32'(c_we), 32'd1);
        end
        alu_valid = 1'b0;
        // Full: this edge pops r10 but refuses the 5th result
        check("drain_ready_full", 32'(md_ready), 32'd0);
        tick();
        check("drain0_we",   32'(c_we), 32'd1);
        check("drain0_addr", 32'(c_addr), 32'd10);
        check("drain0_data", c_in, 32'h0000_0100);
        check("drain0_busy", busy_mask, 32'h0000_7800);
        check("drain_ready_3", 32'(md_ready), 32'd1);
        tick();   // 5th result (r14, 0x104) accepted, r11 popped
        md_valid = 1'b0;
        check("drain1_addr", 32'(c_addr), 32'd11);
        check("drain1_data", c_in, 32'h0000_0101);
        for (int k = 2; k < 5; k++) begin
            tick();
            check($sformatf("drain%0d_we", k), 32'(c_we), 32'd1);
            check($sformatf("drain%0d_addr", k), 32'(c_addr), 32'(10 + k));
            check($sformatf("drain%0d_data", k), c_in, 32'h0100 + 32'(k));
        end
        check("drain_busy_clear", busy_mask, 32'd0);
        tick();
        check("drain_done_we", 32'(c_we), 32'd0);
        // The 5th entry (r14, 0x104) was queued behind r13
        check("drain_last_data", c_in, 32'h0000_0104);

        // Same-edge issue and pop of r9: set wins
        md_issue = 1'b1; md_issue_addr = 5'd9;
        tick();
        md_issue = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
        md_valid  = 1'b1; md_addr = 5'd9; md_data = 32'h99;
        tick();
        check("r9_queued_busy", busy_mask, 32'h0000_0200);
        alu_valid = 1'b0; md_valid = 1'b0;
        md_issue = 1'b1; md_issue_addr = 5'd9;
        tick();
        md_issue = 1'b0;
        check("r9_pop_addr", 32'(c_addr), 32'd9);
        check("r9_pop_we",   32'(c_we), 32'd1);
        check("r9_set_wins", busy_mask, 32'h0000_0200);

        // Reset during queued traffic drops everything
        alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h22;
        md_valid  = 1'b1; md_addr = 5'd20; md_data = 32'h200;
        tick();
        md_addr = 5'd21; md_data = 32'h201;
        tick();
        check("pre_rst_we", 32'(c_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we",    32'(c_we), 32'd0);
        check("mid_rst_busy",  busy_mask, 32'd0);
        check("mid_rst_ready", 32'(md_ready), 32'd1);
        idle_inputs();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("post_rst_we_%0d", k), 32'(c_we), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
